// File: rtl/dm_sba_pkg.sv
// Shared SBA definitions for the debug-module system-bus-access master and
// its bus-side responder.
//   sba_resp_state_e : responder FSM states (IDLE, WAIT, RESP)
//   sba_err_e        : SBA error codes as reported in sbcs.sberror
//   SbaCntW          : width of the responder grant/response delay counter
//   sba_resp_err()   : maps responder error flags onto an SBA error code
package dm_sba_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sba_resp_state_e;

  typedef enum logic [2:0] {
    SbaErrNone      = 3'd0,
    SbaErrBadAddr   = 3'd2,
    SbaErrAlignment = 3'd3,
    SbaErrSize      = 3'd4,
    SbaErrOther     = 3'd7
  } sba_err_e;

  localparam int unsigned SbaCntW = 8;

  function automatic sba_err_e sba_resp_err(input logic r_err, input logic r_other_err);
    if (r_err)       return SbaErrBadAddr;
    if (r_other_err) return SbaErrOther;
    return SbaErrNone;
  endfunction

endpackage

// File: rtl/dm_sba_responder_if.sv
// SBA bus bundle (req/gnt/r_valid protocol).
//   master modport : drives req/add/we/wdata/be, receives gnt and response
//   slave  modport : receives request, drives gnt/r_valid/r_err/r_other_err/r_rdata
interface dm_sba_responder_if #(
  parameter int unsigned BusWidth = 32
);
  logic                    req;
  logic [BusWidth-1:0]     add;
  logic                    we;
  logic [BusWidth-1:0]     wdata;
  logic [BusWidth/8-1:0]   be;
  logic                    gnt;
  logic                    r_valid;
  logic                    r_err;
  logic                    r_other_err;
  logic [BusWidth-1:0]     r_rdata;

  modport master (
    output req, add, we, wdata, be,
    input  gnt, r_valid, r_err, r_other_err, r_rdata
  );

  modport slave (
    input  req, add, we, wdata, be,
    output gnt, r_valid, r_err, r_other_err, r_rdata
  );
endinterface

// File: rtl/dm_sba_resp_mem.sv
// Single-port byte-enabled synchronous RAM backing the SBA responder window.
//   clk_i   : clock
//   en_i    : access enable (one access per enabled cycle)
//   we_i    : 1 = byte-enabled write, 0 = read
//   idx_i   : word index
//   wdata_i : write data, lane-aligned
//   be_i    : byte enables (writes only)
//   rdata_o : read data, valid the cycle after a read and held until the next read
// Contents are deliberately not reset.
module dm_sba_resp_mem #(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned Depth    = 256
) (
  input  logic                       clk_i,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [$clog2(Depth)-1:0]   idx_i,
  input  logic [BusWidth-1:0]        wdata_i,
  input  logic [BusWidth/8-1:0]      be_i,
  output logic [BusWidth-1:0]        rdata_o
);
  localparam int unsigned BeW = BusWidth / 8;

  logic [BusWidth-1:0] mem_q [Depth];
  logic [BusWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < BeW; b++) begin
          if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dm_sba_responder.sv
// Bus-side responder for the debug-module SBA port: a byte-enabled word
// memory window that grants, executes and completes one access at a time
// with programmable grant and response delays.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   slave   : SBA bus (slave modport): req/add/we/wdata/be in,
//             gnt/r_valid/r_err/r_other_err/r_rdata out
module dm_sba_responder
  import dm_sba_pkg::*;
#(
  parameter int unsigned         BusWidth  = 32,
  parameter int unsigned         Depth     = 256,
  parameter logic [BusWidth-1:0] BaseAddr  = '0,
  parameter int unsigned         RoWords   = 0,
  parameter int unsigned         GntDelay  = 0,
  parameter int unsigned         RespDelay = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dm_sba_responder_if.slave  slave
);
  localparam int unsigned BeW     = BusWidth / 8;
  localparam int unsigned AddrLsb = $clog2(BeW);
  localparam int unsigned IdxW    = $clog2(Depth);

  // Window bounds carry one extra bit so BaseAddr + size cannot wrap.
  localparam logic [BusWidth:0]      WinLo   = {1'b0, BaseAddr};
  localparam logic [BusWidth:0]      WinHi   = WinLo + (BusWidth+1)'(Depth * BeW);
  localparam logic [IdxW:0]          RoLim   = (IdxW+1)'(RoWords);
  localparam logic [SbaCntW-1:0]     GntCnt  = SbaCntW'(GntDelay);
  localparam logic [SbaCntW-1:0]     RespCnt = SbaCntW'(RespDelay);

  sba_resp_state_e     state_q, state_d;
  logic [SbaCntW-1:0]  cnt_q, cnt_d;
  logic                r_valid_q, r_valid_d;
  logic                r_err_q, r_err_d;
  logic                r_other_err_q, r_other_err_d;
  logic                rd_ok_q, rd_ok_d;

  logic                gnt;
  logic                in_range;
  logic                ro_word;
  logic [IdxW-1:0]     idx;
  logic [BusWidth:0]   add_ext;
  logic                mem_en;
  logic [BusWidth-1:0] mem_rdata;

  // Address decode
  assign add_ext  = {1'b0, slave.add};
  assign in_range = (add_ext >= WinLo) && (add_ext < WinHi);
  assign idx      = slave.add[AddrLsb +: IdxW];

  if (RoWords == 0) begin : g_no_ro
    assign ro_word = 1'b0;
  end else begin : g_ro
    assign ro_word = ({1'b0, idx} < RoLim);
  end

  // Grant is combinational from state/counter/req so GntDelay==0 grants in the req cycle.
  assign gnt = slave.req &&
               (((state_q == IDLE) && (GntDelay == 0)) ||
                ((state_q == WAIT) && (cnt_q == GntCnt)));

  // Only accesses that actually touch memory are enabled; rejected writes never reach it.
  assign mem_en = gnt && in_range && !(slave.we && ro_word);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    r_valid_d     = 1'b0;
    r_err_d       = r_err_q;
    r_other_err_d = r_other_err_q;
    rd_ok_d       = rd_ok_q;

    unique case (state_q)
      IDLE: begin
        if (slave.req && (GntDelay != 0)) begin
          state_d = WAIT;
          cnt_d   = SbaCntW'(1);
        end
      end
      WAIT: begin
        if (!slave.req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SbaCntW'(1);
        end
      end
      RESP: begin
        if (r_valid_q) begin
          state_d       = IDLE;
          cnt_d         = '0;
          r_err_d       = 1'b0;
          r_other_err_d = 1'b0;
          rd_ok_d       = 1'b0;
        end else begin
          cnt_d     = cnt_q + SbaCntW'(1);
          r_valid_d = ((cnt_q + SbaCntW'(1)) == RespCnt);
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant overrides the per-state bookkeeping above: capture the
    // response and restart the counter from the grant cycle.
    if (gnt) begin
      state_d       = RESP;
      cnt_d         = SbaCntW'(1);
      r_valid_d     = (RespCnt == SbaCntW'(1));
      r_err_d       = !in_range;
      r_other_err_d = in_range && slave.we && ro_word;
      rd_ok_d       = in_range && !slave.we;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      r_valid_q     <= 1'b0;
      r_err_q       <= 1'b0;
      r_other_err_q <= 1'b0;
      rd_ok_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      r_valid_q     <= r_valid_d;
      r_err_q       <= r_err_d;
      r_other_err_q <= r_other_err_d;
      rd_ok_q       <= rd_ok_d;
    end
  end

  dm_sba_resp_mem #(
    .BusWidth (BusWidth),
    .Depth    (Depth)
  ) u_mem (
    .clk_i   (clk_i),
    .en_i    (mem_en),
    .we_i    (slave.we),
    .idx_i   (idx),
    .wdata_i (slave.wdata),
    .be_i    (slave.be),
    .rdata_o (mem_rdata)
  );

  // RAM output register holds the last read; gate it so rdata is zero
  // outside a successful read response.
  assign slave.gnt         = gnt;
  assign slave.r_valid     = r_valid_q;
  assign slave.r_err       = r_err_q;
  assign slave.r_other_err = r_other_err_q;
  assign slave.r_rdata     = rd_ok_q ? mem_rdata : '0;
endmodule

// File: tb/tb_dm_sba_responder.sv
// Self-checking bench for dm_sba_responder. Two instances:
//   A: GntDelay=0, RespDelay=1, RoWords=4
//   B: GntDelay=3, RespDelay=2, RoWords=0
// A shared stimulus bus is steered to one instance by sel; a negedge monitor
// predicts each response at grant time and checks it when r_valid arrives.
module tb_dm_sba_responder;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel, req, we;
  logic [31:0] add, wdata;
  logic [3:0]  be;

  dm_sba_responder_if #(.BusWidth(32)) ifa ();
  dm_sba_responder_if #(.BusWidth(32)) ifb ();

  assign ifa.req = req & ~sel;  assign ifb.req = req & sel;
  assign ifa.add = add;         assign ifb.add = add;
  assign ifa.we = we;           assign ifb.we = we;
  assign ifa.wdata = wdata;     assign ifb.wdata = wdata;
  assign ifa.be = be;           assign ifb.be = be;

  dm_sba_responder #(
    .BusWidth(32), .Depth(256), .BaseAddr(32'h0),
    .RoWords(4), .GntDelay(0), .RespDelay(1)
  ) u_dut_a (.clk_i(clk), .rst_ni(rst_ni), .slave(ifa));

  dm_sba_responder #(
    .BusWidth(32), .Depth(256), .BaseAddr(32'h0),
    .RoWords(0), .GntDelay(3), .RespDelay(2)
  ) u_dut_b (.clk_i(clk), .rst_ni(rst_ni), .slave(ifb));

  logic        gnt_m, rv_m, err_m, oerr_m;
  logic [31:0] rdata_m;
  assign gnt_m   = sel ? ifb.gnt         : ifa.gnt;
  assign rv_m    = sel ? ifb.r_valid     : ifa.r_valid;
  assign err_m   = sel ? ifb.r_err       : ifa.r_err;
  assign oerr_m  = sel ? ifb.r_other_err : ifa.r_other_err;
  assign rdata_m = sel ? ifb.r_rdata     : ifa.r_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int          cyc;
    bit          err;
    bit          oerr;
    bit          skip;
    bit          dc;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_pop;
  logic [31:0] mdl   [2][256];
  bit          known [2][256];
  logic [31:0] dc_rdata;
  int          gnt_cnt = 0;
  int          rv_cnt  = 0;
  bit          rv_prev = 1'b0;

  // Expected response for the access granted this cycle; applies writes to the model.
  function automatic exp_t predict();
    exp_t       e;
    int         s   = sel ? 1 : 0;
    logic [7:0] idx = add[9:2];
    e.cyc   = cyc + (sel ? 2 : 1);
    e.err   = 1'b0;
    e.oerr  = 1'b0;
    e.skip  = we;
    e.dc    = 1'b0;
    e.rdata = '0;
    if (add >= 32'h400) begin
      e.err  = 1'b1;
      e.skip = 1'b0;
    end else if (we && !sel && idx < 8'd4) begin
      e.oerr = 1'b1;
      e.skip = 1'b0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[s][idx][8*b +: 8] = wdata[8*b +: 8];
      if (be == 4'hF) known[s][idx] = 1'b1;
    end else if (known[s][idx]) begin
      e.rdata = mdl[s][idx];
    end else begin
      e.dc = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      rv_prev <= 1'b0;
    end else begin
      if (rv_m) begin
        rv_cnt++;
        chk("rv_width", rv_prev, 0);
        chk("rv_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_pop = sb.pop_front();
          chk("rv_cycle", cyc, e_pop.cyc);
          chk("r_err", err_m, e_pop.err);
          chk("r_other_err", oerr_m, e_pop.oerr);
          if (e_pop.dc) dc_rdata = rdata_m;
          else if (!e_pop.skip) chk("rdata", rdata_m, e_pop.rdata);
        end
      end else if (rv_prev) begin
        chk("rsp_clear", {err_m, oerr_m, rdata_m}, 0);
      end
      if (gnt_m) begin
        gnt_cnt++;
        chk("single_outstanding", sb.size(), 0);
        sb.push_back(predict());
      end
      rv_prev <= rv_m;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("rsp_seen", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic access(input bit s, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    int t0, gc;
    bit got;
    @(posedge clk); #1;
    sel = s; req = 1'b1; we = w; add = a; wdata = d; be = b;
    t0 = cyc; gc = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt_m) begin got = 1'b1; gc = cyc; end
    end
    chk("gnt_seen", got, 1);
    if (got) chk("gnt_latency", gc - t0, s ? 3 : 0);
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] obs_a;
    int          g0, r0;
    bit          got;

    rst_ni = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0;
    add = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_a", {ifa.gnt, ifa.r_valid, ifa.r_err, ifa.r_other_err, ifa.r_rdata}, 0);
    chk("rst_b", {ifb.gnt, ifb.r_valid, ifb.r_err, ifb.r_other_err, ifb.r_rdata}, 0);
    rst_ni = 1'b1;

    // Basic write/read, low address bits ignored
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(0, 0, 32'h10, 32'h0, 4'h0);
    access(0, 0, 32'h13, 32'h0, 4'h0);

    // Byte-lane write: expect 0x1122AB44
    access(0, 1, 32'h14, 32'h11223344, 4'hF);
    access(0, 1, 32'h14, 32'h0000AB00, 4'b0010);
    access(0, 0, 32'h14, 32'h0, 4'h0);

    // be==0 write changes nothing
    access(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0);
    access(0, 0, 32'h10, 32'h0, 4'h0);

    // Window edges
    access(0, 1, 32'h3FC, 32'h12345678, 4'hF);
    access(0, 0, 32'h3FC, 32'h0, 4'h0);
    access(0, 0, 32'h400, 32'h0, 4'h0);
    access(0, 1, 32'h400, 32'hA5A5A5A5, 4'hF);
    access(0, 0, 32'hFFFFFFFC, 32'h0, 4'h0);

    // Read-only word rejects writes and keeps its contents
    access(0, 0, 32'h8, 32'h0, 4'h0);
    obs_a = dc_rdata;
    access(0, 1, 32'h8, 32'h5A5A5A5A, 4'hF);
    access(0, 0, 32'h8, 32'h0, 4'h0);
    chk("ro_unchanged", dc_rdata, obs_a);

    // req held through r_valid: grants every other cycle, never back-to-back
    @(posedge clk); #1;
    sel = 1'b0; req = 1'b1; we = 1'b0; add = 32'h10; g0 = gnt_cnt;
    repeat (8) @(posedge clk);
    #1; req = 1'b0;
    wait_idle();
    chk("hold_gnt_count", gnt_cnt - g0, 4);

    // Random traffic over writable words
    for (int i = 4; i < 16; i++) access(0, 1, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 24; i++)
      access(0, 1'($urandom_range(0, 1)), 32'($urandom_range(4, 15) * 4),
             $urandom, 4'($urandom_range(0, 15)));

    // Delayed grant/response instance
    access(1, 1, 32'h40, 32'h0BADF00D, 4'hF);
    access(1, 0, 32'h40, 32'h0, 4'h0);

    // req dropped while waiting: no grant
    @(posedge clk); #1;
    sel = 1'b1; req = 1'b1; we = 1'b0; add = 32'h40; g0 = gnt_cnt;
    repeat (2) @(posedge clk);
    #1; req = 1'b0;
    repeat (6) @(posedge clk);
    chk("abort_no_gnt", gnt_cnt - g0, 0);
    access(1, 0, 32'h40, 32'h0, 4'h0);

    // Reset while a response is pending
    access(1, 1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    sel = 1'b1; req = 1'b1; we = 1'b0; add = 32'h20; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt_m) got = 1'b1;
    end
    chk("rst_gnt_seen", got, 1);
    @(posedge clk); #1;
    req = 1'b0; rst_ni = 1'b0; r0 = rv_cnt;
    repeat (2) @(posedge clk);
    #1; rst_ni = 1'b1;
    sb.delete();
    chk("rst_mid_out", {ifb.r_valid, ifb.r_err, ifb.r_other_err, ifb.r_rdata}, 0);
    repeat (6) @(negedge clk);
    chk("rst_no_rv", rv_cnt - r0, 0);
    access(1, 0, 32'h20, 32'h0, 4'h0);
    access(0, 0, 32'h3FC, 32'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
